// File: rtl/hidden_cpu_pkg.sv
// Shared opcode/subop constants and FSM encoding for the parametrised HiddenCPU core.
package hidden_cpu_pkg;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_XOR = 3'd3;
   localparam logic [2:0] OP_MOV = 3'd4;
   localparam logic [2:0] OP_ST  = 3'd5;
   localparam logic [2:0] OP_LD  = 3'd6;
   localparam logic [2:0] OP_SYS = 3'd7;

   // Subops live in the rs field, whose width varies with NREG, so compare as int.
   localparam int SYS_BCF = 0;
   localparam int SYS_TOG = 1;
   localparam int SYS_CLC = 2;

   typedef enum logic {
      EXEC = 1'b0,
      LDWB = 1'b1
   } state_t;

endpackage

// File: rtl/hidden_cpu_gen_if.sv
// Instruction stream into the core: valid/ready handshake, instruction held by the master.
interface hidden_cpu_gen_if #(
   parameter int IW = 7
);
   logic          instr_valid;
   logic          instr_ready;
   logic [IW-1:0] instr;

   modport master (output instr_valid, output instr, input instr_ready);
   modport slave  (input instr_valid, input instr, output instr_ready);
endinterface

// File: rtl/hidden_cpu_alu.sv
// Combinational ALU: ADD/SUB produce carry/borrow and request a carry write; others leave carry alone.
module hidden_cpu_alu
   import hidden_cpu_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [2:0]        op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] result,
   output logic              carry_out,
   output logic              carry_we
);

   logic [DATA_W:0] sumWide;
   logic [DATA_W:0] diffWide;

   // The extra top bit of the difference is set exactly when a < b (unsigned).
   assign sumWide  = {1'b0, a} + {1'b0, b};
   assign diffWide = {1'b0, a} - {1'b0, b};

   always_comb begin
      result    = a;
      carry_out = 1'b0;
      carry_we  = 1'b0;
      case (op)
         OP_ADD: begin
            result    = sumWide[DATA_W-1:0];
            carry_out = sumWide[DATA_W];
            carry_we  = 1'b1;
         end
         OP_SUB: begin
            result    = diffWide[DATA_W-1:0];
            carry_out = diffWide[DATA_W];
            carry_we  = 1'b1;
         end
         OP_AND:  result = a & b;
         OP_XOR:  result = a ^ b;
         OP_MOV:  result = b;
         default: result = a;
      endcase
   end

endmodule

// File: rtl/hidden_cpu_gen.sv
// Parametrised HiddenCPU core: one instruction per cycle, LD takes 2 cycles.
// Backpressure: instr_ready drops for the LD writeback cycle; offered instructions then are ignored.
module hidden_cpu_gen
   import hidden_cpu_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int NREG      = 4,
   parameter int RAM_DEPTH = 8,
   parameter int PC_W      = 8
) (
   input  logic               clk,
   input  logic               rst,
   hidden_cpu_gen_if.slave    instrBus,
   output logic [DATA_W-1:0]  out_data,
   output logic               out_sel,
   output logic [PC_W-1:0]    pc,
   output logic               carry
);

   localparam int RW = $clog2(NREG);
   localparam int AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

   state_t            state;
   state_t            stateNxt;
   logic              accept;
   logic [2:0]        op;
   logic [RW-1:0]     rd;
   logic [RW-1:0]     rs;
   int                rsIdx;
   logic [DATA_W-1:0] regs [NREG];
   logic [DATA_W-1:0] ram  [RAM_DEPTH];
   logic [DATA_W-1:0] rdVal;
   logic [DATA_W-1:0] rsVal;
   logic [AW-1:0]     ldAddr;
   logic [RW-1:0]     ldDst;
   logic [DATA_W-1:0] aluRes;
   logic              aluCarry;
   logic              aluCarryWe;
   logic [PC_W-1:0]   branchOff;

   assign op     = instrBus.instr[2*RW+2 -: 3];
   assign rd     = instrBus.instr[2*RW-1 -: RW];
   assign rs     = instrBus.instr[RW-1:0];
   assign rsIdx  = int'(rs);
   assign accept = instrBus.instr_valid & instrBus.instr_ready;

   assign rdVal     = regs[rd];
   assign rsVal     = regs[rs];
   assign branchOff = PC_W'(rdVal);

   // Both sources are registers, so the mux only moves at a clock edge.
   assign out_data = out_sel ? DATA_W'(pc) : regs[NREG-1];

   hidden_cpu_alu #(.DATA_W(DATA_W)) uAlu (
      .op       (op),
      .a        (rdVal),
      .b        (rsVal),
      .result   (aluRes),
      .carry_out(aluCarry),
      .carry_we (aluCarryWe)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= EXEC;
      else     state <= stateNxt;
   end

   always_comb begin
      stateNxt = state;
      case (state)
         EXEC:    if (accept && op == OP_LD) stateNxt = LDWB;
         LDWB:    stateNxt = EXEC;
         default: stateNxt = EXEC;
      endcase
   end

   always_comb begin
      instrBus.instr_ready = (state == EXEC);
   end

   // RAM is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (!rst && accept && op == OP_ST) ram[AW'(rdVal)] <= rsVal;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) regs[i] <= DATA_W'(i);
         pc      <= '0;
         carry   <= 1'b0;
         out_sel <= 1'b0;
         ldAddr  <= '0;
         ldDst   <= '0;
      end else if (state == LDWB) begin
         regs[ldDst] <= ram[ldAddr];
      end else if (accept) begin
         pc <= pc + PC_W'(1);
         case (op)
            OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_MOV: begin
               regs[rd] <= aluRes;
               if (aluCarryWe) carry <= aluCarry;
            end
            OP_LD: begin
               ldAddr <= AW'(rsVal);
               ldDst  <= rd;
            end
            OP_SYS: begin
               if (rsIdx == SYS_BCF) begin
                  if (carry) pc <= pc + branchOff;
               end else if (rsIdx == SYS_TOG) begin
                  out_sel <= ~out_sel;
               end else if (rsIdx == SYS_CLC) begin
                  carry <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_hidden_cpu_gen.sv
// Directed bench for hidden_cpu_gen: default instance plus a DATA_W=12/NREG=8/RAM_DEPTH=16 instance.
module tb_hidden_cpu_gen;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rst2 = 1'b1;
   int   vecs = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   hidden_cpu_gen_if #(.IW(7)) bus ();
   hidden_cpu_gen_if #(.IW(9)) bus2 ();

   logic [7:0]  out_data;
   logic        out_sel;
   logic [7:0]  pc;
   logic        carry;
   logic [11:0] out_data2;
   logic        out_sel2;
   logic [7:0]  pc2;
   logic        carry2;

   hidden_cpu_gen dut (
      .clk(clk), .rst(rst), .instrBus(bus.slave),
      .out_data(out_data), .out_sel(out_sel), .pc(pc), .carry(carry)
   );

   hidden_cpu_gen #(.DATA_W(12), .NREG(8), .RAM_DEPTH(16), .PC_W(8)) dut2 (
      .clk(clk), .rst(rst2), .instrBus(bus2.slave),
      .out_data(out_data2), .out_sel(out_sel2), .pc(pc2), .carry(carry2)
   );

   function automatic logic [6:0] enc(input int o, input int d, input int s);
      return {3'(o), 2'(d), 2'(s)};
   endfunction

   function automatic logic [8:0] enc2(input int o, input int d, input int s);
      return {3'(o), 3'(d), 3'(s)};
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Offers one instruction and returns 1 time unit after the accepting edge.
   task automatic issue(input logic [6:0] ins);
      int n = 0;
      @(negedge clk);
      while (bus.instr_ready !== 1'b1 && n < 8) begin
         @(negedge clk);
         n++;
      end
      vecs++;
      if (n >= 8) begin
         miscompares++;
         $display("FAIL issue_timeout: instr_ready=%b required 1", bus.instr_ready);
      end
      bus.instr = ins;
      bus.instr_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.instr_valid = 1'b0;
   endtask

   task automatic issue2(input logic [8:0] ins);
      int n = 0;
      @(negedge clk);
      while (bus2.instr_ready !== 1'b1 && n < 8) begin
         @(negedge clk);
         n++;
      end
      vecs++;
      if (n >= 8) begin
         miscompares++;
         $display("FAIL issue2_timeout: instr_ready=%b required 1", bus2.instr_ready);
      end
      bus2.instr = ins;
      bus2.instr_valid = 1'b1;
      @(posedge clk);
      #1;
      bus2.instr_valid = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         vecs++;
         if (dut.regs[i] !== 8'(i)) begin
            miscompares++;
            $display("FAIL reset_r%0d: got %0d required %0d", i, dut.regs[i], i);
         end
      end
      vecs++; if (pc !== 8'd0) begin miscompares++; $display("FAIL reset_pc: got %0d required 0", pc); end
      vecs++; if (out_data !== 8'd3) begin miscompares++; $display("FAIL reset_out_data: got %0d required 3", out_data); end
      vecs++; if (carry !== 1'b0) begin miscompares++; $display("FAIL reset_carry: got %b required 0", carry); end
      vecs++; if (bus.instr_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b required 1", bus.instr_ready); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_add_carry();
      logic [7:0] expR;
      logic       expC;
      do_reset();
      issue(enc(4, 0, 3));
      vecs++; if (dut.regs[0] !== 8'd3) begin miscompares++; $display("FAIL mov_r0: got %0d required 3", dut.regs[0]); end
      for (int k = 1; k <= 7; k++) begin
         issue(enc(0, 0, 0));
         expR = 8'(3 << k);
         expC = (k == 7);
         vecs++; if (dut.regs[0] !== expR) begin miscompares++; $display("FAIL add_r0_step%0d: got %0d required %0d", k, dut.regs[0], expR); end
         vecs++; if (carry !== expC) begin miscompares++; $display("FAIL add_carry_step%0d: got %b required %b", k, carry, expC); end
         if (k == 6) begin
            vecs++; if (pc !== 8'd7) begin miscompares++; $display("FAIL add_pc7: got %0d required 7", pc); end
         end
      end
      vecs++; if (pc !== 8'd8) begin miscompares++; $display("FAIL add_pc8: got %0d required 8", pc); end
   endtask

   task automatic test_ld_st_stall();
      do_reset();
      issue(enc(5, 2, 3));
      issue(enc(6, 1, 2));
      vecs++; if (bus.instr_ready !== 1'b0) begin miscompares++; $display("FAIL ld_stall_ready: got %b required 0", bus.instr_ready); end
      vecs++; if (pc !== 8'd2) begin miscompares++; $display("FAIL ld_pc_stall: got %0d required 2", pc); end
      vecs++; if (dut.regs[1] !== 8'd1) begin miscompares++; $display("FAIL ld_r1_early: got %0d required 1", dut.regs[1]); end
      // Offer an ADD r3,r3 while stalled; it must be dropped.
      bus.instr = enc(0, 3, 3);
      bus.instr_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.instr_valid = 1'b0;
      vecs++; if (bus.instr_ready !== 1'b1) begin miscompares++; $display("FAIL ld_ready_back: got %b required 1", bus.instr_ready); end
      vecs++; if (dut.regs[1] !== 8'd3) begin miscompares++; $display("FAIL ld_r1: got %0d required 3", dut.regs[1]); end
      vecs++; if (pc !== 8'd2) begin miscompares++; $display("FAIL ld_pc_after: got %0d required 2", pc); end
      vecs++; if (dut.regs[3] !== 8'd3) begin miscompares++; $display("FAIL stall_ignored_r3: got %0d required 3", dut.regs[3]); end
   endtask

   task automatic test_branch();
      do_reset();
      issue(enc(1, 0, 1));
      vecs++; if (dut.regs[0] !== 8'd255) begin miscompares++; $display("FAIL sub_r0: got %0d required 255", dut.regs[0]); end
      vecs++; if (carry !== 1'b1) begin miscompares++; $display("FAIL sub_borrow: got %b required 1", carry); end
      for (int i = 0; i < 4; i++) issue(enc(7, 0, 3));
      vecs++; if (pc !== 8'd5 || carry !== 1'b1) begin miscompares++; $display("FAIL nop_pc_carry: got pc=%0d c=%b required pc=5 c=1", pc, carry); end
      issue(enc(7, 3, 0));
      vecs++; if (pc !== 8'd8) begin miscompares++; $display("FAIL bcf_taken: got %0d required 8", pc); end
      issue(enc(7, 0, 2));
      vecs++; if (carry !== 1'b0 || pc !== 8'd9) begin miscompares++; $display("FAIL clc: got c=%b pc=%0d required c=0 pc=9", carry, pc); end
      issue(enc(7, 3, 0));
      vecs++; if (pc !== 8'd10) begin miscompares++; $display("FAIL bcf_not_taken: got %0d required 10", pc); end
   endtask

   task automatic test_tog();
      do_reset();
      issue(enc(7, 0, 1));
      vecs++; if (out_sel !== 1'b1 || out_data !== 8'd1) begin miscompares++; $display("FAIL tog1: got sel=%b data=%0d required sel=1 data=1", out_sel, out_data); end
      issue(enc(7, 0, 3));
      vecs++; if (out_data !== 8'd2) begin miscompares++; $display("FAIL tog_pc_follow: got %0d required 2", out_data); end
      issue(enc(7, 0, 1));
      vecs++; if (out_sel !== 1'b0 || out_data !== 8'd3) begin miscompares++; $display("FAIL tog2: got sel=%b data=%0d required sel=0 data=3", out_sel, out_data); end
   endtask

   task automatic test_rd_eq_rs();
      do_reset();
      issue(enc(1, 0, 1));
      issue(enc(3, 2, 2));
      vecs++; if (dut.regs[2] !== 8'd0) begin miscompares++; $display("FAIL xor_self: got %0d required 0", dut.regs[2]); end
      issue(enc(2, 3, 1));
      vecs++; if (out_data !== 8'd1) begin miscompares++; $display("FAIL and_r3: got %0d required 1", out_data); end
      vecs++; if (carry !== 1'b1) begin miscompares++; $display("FAIL logic_keeps_carry: got %b required 1", carry); end
      issue(enc(0, 1, 1));
      vecs++; if (dut.regs[1] !== 8'd2 || carry !== 1'b0) begin miscompares++; $display("FAIL add_self: got r1=%0d c=%b required r1=2 c=0", dut.regs[1], carry); end
   endtask

   task automatic test_mid_ld_reset();
      do_reset();
      issue(enc(5, 0, 3));
      issue(enc(6, 2, 0));
      vecs++; if (bus.instr_ready !== 1'b0) begin miscompares++; $display("FAIL midld_in_ldwb: got ready=%b required 0", bus.instr_ready); end
      #1 rst = 1'b1;
      #1;
      vecs++; if (bus.instr_ready !== 1'b1 || pc !== 8'd0) begin miscompares++; $display("FAIL midld_async: got ready=%b pc=%0d required ready=1 pc=0", bus.instr_ready, pc); end
      vecs++; if (dut.regs[2] !== 8'd2) begin miscompares++; $display("FAIL midld_r2_during: got %0d required 2", dut.regs[2]); end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      vecs++; if (dut.regs[2] !== 8'd2 || bus.instr_ready !== 1'b1) begin miscompares++; $display("FAIL midld_after: got r2=%0d ready=%b required r2=2 ready=1", dut.regs[2], bus.instr_ready); end
   endtask

   task automatic test_param();
      @(negedge clk);
      rst2 = 1'b0;
      #1;
      vecs++; if (out_data2 !== 12'd7) begin miscompares++; $display("FAIL p_reset_r7: got %0d required 7", out_data2); end
      vecs++; if (dut2.regs[5] !== 12'd5) begin miscompares++; $display("FAIL p_reset_r5: got %0d required 5", dut2.regs[5]); end
      issue2(enc2(1, 0, 1));
      vecs++; if (dut2.regs[0] !== 12'd4095 || carry2 !== 1'b1) begin miscompares++; $display("FAIL p_sub: got r0=%0d c=%b required r0=4095 c=1", dut2.regs[0], carry2); end
      issue2(enc2(7, 0, 2));
      vecs++; if (carry2 !== 1'b0) begin miscompares++; $display("FAIL p_clc: got %b required 0", carry2); end
      issue2(enc2(0, 0, 1));
      vecs++; if (dut2.regs[0] !== 12'd0 || carry2 !== 1'b1) begin miscompares++; $display("FAIL p_add_wrap: got r0=%0d c=%b required r0=0 c=1", dut2.regs[0], carry2); end
      vecs++; if (pc2 !== 8'd3) begin miscompares++; $display("FAIL p_pc: got %0d required 3", pc2); end
   endtask

   initial begin
      bus.instr_valid  = 1'b0;
      bus.instr        = '0;
      bus2.instr_valid = 1'b0;
      bus2.instr       = '0;
      repeat (2) @(negedge clk);
      test_reset();
      test_add_carry();
      test_ld_st_stall();
      test_branch();
      test_tog();
      test_rd_eq_rs();
      test_mid_ld_reset();
      test_param();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
      $finish;
   end

endmodule

// File: doc/hidden_cpu_gen.md
Name: hidden_cpu_gen

Overview:
Parametrised successor to the 8-bit HiddenCPU core. It has configurable data width, register count and RAM depth. Instructions arrive on a valid/ready stream rather than being sampled every clock. Loads are two-cycle and stall the stream; the core adds an explicit clear-carry operation and a registered output mux. It sits behind the tile I/O wrapper, which drives the instruction stream and presents out_data on the pins.

Parameters:
DATA_W, 8, register/RAM/ALU width (>=4)
NREG, 4, number of general registers (power of 2, >=2); RW = clog2(NREG)
RAM_DEPTH, 8, internal RAM words (power of 2, <=2^DATA_W)
PC_W, 8, program counter width

Ports:
clk  in  1  core clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
instr_valid  in  1  instruction present on instr
instr_ready  out  1  core can accept instruction this cycle
instr  in  3+2*RW  {op[2:0], rd[RW-1:0], rs[RW-1:0]}
out_data  out  DATA_W  out_sel ? pc (zero-extend/truncate to DATA_W) : r[NREG-1]
out_sel  out  1  output source select
pc  out  PC_W  program counter
carry  out  1  carry/borrow flag

Behaviour:
- Reset, asynchronous: r[i]=i (mod 2^DATA_W), pc=0, carry=0, out_sel=0, FSM=EXEC, instr_ready=1. RAM contents are not reset.
- Accept = instr_valid & instr_ready. No accept -> no state change except LD completion. pc += 1 (wraps mod 2^PC_W) on every accept, unless a branch is taken.
- FSM states:
  - EXEC: instr_ready=1; executes accepted op in one cycle.
  - LDWB: instr_ready=0; entered after an accepted LD; performs writeback and returns to EXEC next cycle. LD latency is therefore 2 cycles, throughput 1 instruction per 2 cycles.
- Opcodes (results mod 2^DATA_W):
  - 0 ADD: rd=rd+rs; carry=carry-out.
  - 1 SUB: rd=rd-rs; carry=borrow (rd<rs unsigned).
  - 2 AND: rd=rd&rs; carry unchanged.
  - 3 XOR: rd=rd^rs; carry unchanged.
  - 4 MOV: rd=rs.
  - 5 ST: RAM[r[rd] mod RAM_DEPTH] <= r[rs].
  - 6 LD: address = r[rs] mod RAM_DEPTH is captured in EXEC; r[rd] <= RAM[addr] in LDWB.
  - 7 SYS: rs field selects the subop:
    - 0 BCF: if carry, pc <= pc + r[rd] (zero-extended, wraps) instead of +1.
    - 1 TOG: out_sel toggles.
    - 2 CLC: carry=0.
    - other: NOP.
- Branch offset is unsigned; the offset is added to the pc of the BCF itself.
- rd==rs is legal everywhere: operands are read before the writeback edge.
- ST immediately followed by LD of the same address returns the new data. RAM writes at the edge of ST; the LD read occurs next cycle.
- instr/instr_valid while instr_ready=0 are ignored, not queued. The wrapper must hold the instruction.
- Reset during LDWB aborts the writeback: the destination holds its reset value.
- out_data is combinational from registered state. No output glitch is tolerated across a TOG except at the clock edge.

Decomposition:
- Package hidden_cpu_pkg: opcode constants OP_ADD..OP_SYS, subop constants SYS_BCF/SYS_TOG/SYS_CLC, FSM state encoding (EXEC, LDWB).
- One sub-module, hidden_cpu_alu (combinational):
  - Inputs: op, a, b.
  - Outputs: result, carry_out, carry_we.
  - Parametrised by DATA_W.
- Register file, RAM, pc and FSM stay in hidden_cpu_gen.

Test Plan:
- Reset with defaults -> r0..r3=0,1,2,3; pc=0; out_data=3; carry=0; instr_ready=1.
- Register add with carry out: MOV r0<-r3, then ADD r0,r0 repeated until overflow (r0=3,6,12,...,192, then 384 mod 256=128) -> carry=1 on the overflowing ADD only; pc=7 after 7 accepts.
- Load/store with stall: ST [r2]<-r3 (RAM[2]=3), then LD r1<-[r2] -> instr_ready low exactly one cycle; r1=3 in LDWB+1; pc advances by 1 for LD, not 2.
- Branch taken/not taken: SUB r0,r1 with r0=0,r1=1 -> carry=1, r0=255; BCF r3 at pc=5 -> pc=8. CLC then BCF -> pc increments by 1.
- Output select: TOG -> out_data=pc; second TOG -> out_data=r3. Parameter run DATA_W=12, NREG=8, RAM_DEPTH=16: reset r7=7; ADD 4095+1 -> 0 with carry=1.
- Mid-LD reset: assert rst asynchronously during LDWB -> immediate reset values; destination unchanged from reset; instr_ready=1 after release. instr_valid pulsing while stalled -> ignored, pc unchanged.
